// File: rtl/cafe_pkg.sv
// rtl/cafe_pkg.sv - drink, sequencer state types and recipe durations for the dispense sequencer
package cafe_pkg;

    typedef enum logic [1:0] {
        EXPRESO    = 2'd0,
        CAFE_LECHE = 2'd1,
        CAPUCCINO  = 2'd2,
        CHOCOLATE  = 2'd3
    } drink_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATER  = 3'd1,
        COFFEE = 3'd2,
        MILK   = 3'd3,
        CHOCO  = 3'd4,
        SUGAR  = 3'd5,
        FIN    = 3'd6
    } seq_state_t;

    localparam int DUR_W = 4;

    localparam logic [DUR_W-1:0] DUR_EXPRESO_WATER     = 4'd2;
    localparam logic [DUR_W-1:0] DUR_EXPRESO_COFFEE    = 4'd3;
    localparam logic [DUR_W-1:0] DUR_EXPRESO_MILK      = 4'd0;
    localparam logic [DUR_W-1:0] DUR_EXPRESO_CHOCO     = 4'd0;
    localparam logic [DUR_W-1:0] DUR_CAFE_LECHE_WATER  = 4'd2;
    localparam logic [DUR_W-1:0] DUR_CAFE_LECHE_COFFEE = 4'd2;
    localparam logic [DUR_W-1:0] DUR_CAFE_LECHE_MILK   = 4'd3;
    localparam logic [DUR_W-1:0] DUR_CAFE_LECHE_CHOCO  = 4'd0;
    localparam logic [DUR_W-1:0] DUR_CAPUCCINO_WATER   = 4'd1;
    localparam logic [DUR_W-1:0] DUR_CAPUCCINO_COFFEE  = 4'd2;
    localparam logic [DUR_W-1:0] DUR_CAPUCCINO_MILK    = 4'd4;
    localparam logic [DUR_W-1:0] DUR_CAPUCCINO_CHOCO   = 4'd0;
    localparam logic [DUR_W-1:0] DUR_CHOCOLATE_WATER   = 4'd3;
    localparam logic [DUR_W-1:0] DUR_CHOCOLATE_COFFEE  = 4'd0;
    localparam logic [DUR_W-1:0] DUR_CHOCOLATE_MILK    = 4'd2;
    localparam logic [DUR_W-1:0] DUR_CHOCOLATE_CHOCO   = 4'd4;

    // Ingredient step duration in ticks; SUGAR depends on the latched request, not the drink.
    function automatic logic [DUR_W-1:0] step_dur(input drink_t d, input seq_state_t s);
        logic [DUR_W-1:0] r;
        r = '0;
        case (s)
            WATER: begin
                case (d)
                    EXPRESO:    r = DUR_EXPRESO_WATER;
                    CAFE_LECHE: r = DUR_CAFE_LECHE_WATER;
                    CAPUCCINO:  r = DUR_CAPUCCINO_WATER;
                    default:    r = DUR_CHOCOLATE_WATER;
                endcase
            end
            COFFEE: begin
                case (d)
                    EXPRESO:    r = DUR_EXPRESO_COFFEE;
                    CAFE_LECHE: r = DUR_CAFE_LECHE_COFFEE;
                    CAPUCCINO:  r = DUR_CAPUCCINO_COFFEE;
                    default:    r = DUR_CHOCOLATE_COFFEE;
                endcase
            end
            MILK: begin
                case (d)
                    EXPRESO:    r = DUR_EXPRESO_MILK;
                    CAFE_LECHE: r = DUR_CAFE_LECHE_MILK;
                    CAPUCCINO:  r = DUR_CAPUCCINO_MILK;
                    default:    r = DUR_CHOCOLATE_MILK;
                endcase
            end
            CHOCO: begin
                case (d)
                    EXPRESO:    r = DUR_EXPRESO_CHOCO;
                    CAFE_LECHE: r = DUR_CAFE_LECHE_CHOCO;
                    CAPUCCINO:  r = DUR_CAPUCCINO_CHOCO;
                    default:    r = DUR_CHOCOLATE_CHOCO;
                endcase
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - per-step tick counter that flags the tick completing the programmed duration
module tick_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = en & (count == dur - CNT_W'(1));

endmodule

// File: rtl/bebida_secuenciador.sv
// rtl/bebida_secuenciador.sv - recipe dispense sequencer; SUGAR_STEP_EN adds the optional sugar step
module bebida_secuenciador #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [1:0] drink,
    input  logic       sugar_req,
    input  logic       cancel,
    output logic       busy,
    output logic       done,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       choco,
    output logic       azucar,
    output logic [2:0] step
);

    import cafe_pkg::*;

    seq_state_t       state_q;
    seq_state_t       state_d;
    drink_t           drink_q;
    logic             sugar_q;
    logic             sugar_in;
    logic             load;
    logic             clr;
    logic             expire;
    logic [CNT_W-1:0] cur_dur;

    function automatic logic [CNT_W-1:0] dur_of(input drink_t d, input logic s, input seq_state_t st);
        if (st == SUGAR) begin
            return CNT_W'(s);
        end
        return CNT_W'(step_dur(d, st));
    endfunction

    // First step after `from` with a nonzero duration, so empty steps cost no cycle.
    function automatic seq_state_t next_step(input seq_state_t from, input drink_t d, input logic s);
        seq_state_t r;
        r = FIN;
        for (int i = 5; i >= 1; i--) begin
            if (3'(i) > from && dur_of(d, s, seq_state_t'(3'(i))) != '0) begin
                r = seq_state_t'(3'(i));
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d = next_step(IDLE, drink_t'(drink), sugar_in);
                    load    = 1'b1;
                end
            end
            WATER, COFFEE, MILK, CHOCO, SUGAR: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = next_step(state_q, drink_q, sugar_q);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Restart the count on every state change so each step measures only its own ticks.
    assign clr     = (state_d != state_q) || (state_q == IDLE);
    assign cur_dur = dur_of(drink_q, sugar_q, state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drink_q <= EXPRESO;
        end else begin
            state_q <= state_d;
            if (load) begin
                drink_q <= drink_t'(drink);
            end
        end
    end

`ifdef SUGAR_STEP_EN
    assign sugar_in = sugar_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            sugar_q <= 1'b0;
        end else if (load) begin
            sugar_q <= sugar_req;
        end
    end

    assign azucar = (state_q == SUGAR);
`else
    logic unused_sugar_req;
    assign unused_sugar_req = sugar_req;
    assign sugar_in         = 1'b0;
    assign sugar_q          = 1'b0;
    assign azucar           = 1'b0;
`endif

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_tick_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (tick),
        .dur    (cur_dur),
        .expire (expire)
    );

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);
    assign agua  = (state_q == WATER);
    assign cafe  = (state_q == COFFEE);
    assign leche = (state_q == MILK);
    assign choco = (state_q == CHOCO);
    assign step  = state_q;

endmodule

// File: doc/bebida_secuenciador.md
# bebida_secuenciador

Dispense sequencer for the coffee machine: once payment is accepted, it runs the selected drink's recipe. It drives the ingredient valves (agua, cafe, leche, choco, azucar) one at a time, each for a fixed number of 1 Hz ticks. It sits between the payment FSM, which issues `start` and `drink`, and the valve outputs, and it returns a one-cycle `done`.

## Interface
- `CNT_W`, default 4: width of the per-step tick counter; every recipe duration must be ≤ 2^CNT_W − 1.
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: 1 Hz enable, one `clk` cycle wide, from the frequency divider.
- `start` in 1: request to begin a recipe; honoured only in IDLE.
- `drink` in 2: recipe select. 0 = expreso, 1 = cafe con leche, 2 = capuccino, 3 = chocolate.
- `sugar_req` in 1: add a sugar step; sampled together with `start`.
- `cancel` in 1: abort the running recipe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a recipe completes normally.
- `agua`, `cafe`, `leche`, `choco`, `azucar` out 1 each: valve enables, at most one high at a time.
- `step` out 3: current state encoding, for debug and display.

## Operation
- States:
  - IDLE → WATER → COFFEE → MILK → CHOCO → SUGAR → FIN → IDLE.
  - The order is fixed. Any step whose duration is 0 for the latched drink is skipped in the same transition.
- Recipe durations in ticks, listed as water/coffee/milk/choco:
  - expreso 2/3/0/0
  - cafe con leche 2/2/3/0
  - capuccino 1/2/4/0
  - chocolate 3/0/2/4
  - SUGAR lasts 1 tick when the latched `sugar_req` = 1, otherwise 0.
- Valve mapping: Moore outputs, each a function of state only.
  - WATER → `agua`, COFFEE → `cafe`, MILK → `leche`, CHOCO → `choco`, SUGAR → `azucar`.
- Starting a recipe: in IDLE with `start` = 1 and `cancel` = 0:
  - `drink` and `sugar_req` are latched into internal registers.
  - The next state is the first step with nonzero duration.
  - Later changes on `drink` or `sugar_req` are ignored.
- Step counter:
  - Cleared on entry to every step.
  - Increments on each `tick`.
  - When `tick` = 1 and count = duration − 1, the FSM moves to the next nonzero step, or to FIN if none remains.
- FIN lasts exactly one cycle, with `done` = 1 and all valves 0. The next state is IDLE.
- Cancel: `cancel` = 1 in any non-IDLE state sends the FSM to IDLE next cycle. All valves go low, `done` stays 0, and the counter clears.
- `start` while busy is ignored. It is not queued.

## Timing
- Reset values: state IDLE, counter 0, latched drink 0, latched sugar 0. All outputs are 0 (`busy`, `done`, every valve, `step` = 0).
- Start latency: the first valve rises in the cycle after `start` is sampled, and `busy` rises in the same cycle.
- Step length:
  - A step ends on the clock edge where its duration-th `tick` is counted.
  - Ticks arriving in the cycle a step is entered are not counted for that step.
  - The first tick of a step may therefore come from 1 clk cycle up to 1 s after entry.
- Valve transitions are break-before-make with zero gap: the outgoing valve falls and the incoming valve rises on the same edge. Two valves are never high together.
- Simultaneous events:
  - `cancel` beats `tick`.
  - `cancel` + `start` in IDLE: start is ignored.
  - `tick` + `start` in IDLE: the tick is ignored.
  - `rst` beats everything.
- Reset mid-recipe: IDLE in the next cycle, valves off, no `done`.
- Counter wrap is impossible, because every duration is below 2^CNT_W.

## Configuration
- `SUGAR_STEP_EN` defined:
  - The SUGAR state exists and `sugar_req` is latched.
  - `azucar` is driven as described above.
- `SUGAR_STEP_EN` undefined:
  - The SUGAR state is absent and the last nonzero step goes straight to FIN.
  - `sugar_req` is ignored and `azucar` is tied to 0.
  - The `step` encoding of all other states is unchanged.

## Structure
- Package `cafe_pkg` holds:
  - `drink_t` (2-bit enum).
  - `seq_state_t` (3-bit enum; values IDLE = 0 … FIN = 6, fixed).
  - Duration constants `DUR_<DRINK>_<ING>`.
  - Function `step_dur(drink_t, seq_state_t)` returning a `CNT_W`-wide duration.
- One sub-module, `tick_timer`: tick counter with `clr`, `en = tick`, and comparison against a duration input. It outputs `expire` = `tick` & (count = dur − 1).

## Test plan
- Reset, then `start`, `drink` = 0, `sugar_req` = 0 → `agua` high for 2 ticks, then `cafe` for 3 ticks, then `done` pulses exactly one cycle and `busy` falls; `leche`, `choco` and `azucar` never rise.
- `drink` = 3, `sugar_req` = 1 (`SUGAR_STEP_EN` defined) → agua 3, leche 2, choco 4, azucar 1, then `done`; COFFEE is skipped with no idle cycle.
- `drink` = 2; change `drink` to 0 and pulse `start` during MILK → recipe continues unchanged (leche runs 4 ticks); the second start is ignored.
- `drink` = 1, assert `cancel` during COFFEE in the same cycle as `tick` → IDLE next cycle, all valves 0, no `done` pulse.
- Assert `rst` during WATER → IDLE next cycle, all outputs 0; a following `start` with `drink` = 0 runs normally from WATER.
- `SUGAR_STEP_EN` undefined, `drink` = 0, `sugar_req` = 1 → sequence identical to the first scenario; `azucar` stays 0 throughout.
